// File: rtl/btn_cmd_conditioner_pkg.sv
// Shared definitions for the push-button command front end: button indices and
// the debounce length helper.
package btn_cmd_conditioner_pkg;

    localparam int BTN_CNT = 3;

    typedef enum logic [1:0] {
        BTN_PAUSE = 2'd0,
        BTN_CFG_1 = 2'd1,
        BTN_CFG_2 = 2'd2
    } btn_idx_e;

    // Clock cycles a level must stay stable before it is accepted.
    function automatic int db_cycles(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/btn_cmd_conditioner_debounce_channel.sv
// One button: 2-flop synchroniser, polarity normalise, DB-sample debounce, press pulse.
// Level changes DB+2 edges after the raw pin; pulse is registered with the level flip. No backpressure.
module btn_cmd_conditioner_debounce_channel #(
    parameter int DB         = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press_pulse
);

    localparam int   CW           = (DB > 1) ? $clog2(DB) : 1;
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    logic          sync_1;
    logic          sync_2;
    logic          pressed;
    logic          stable;
    logic [CW-1:0] cnt;

    assign pressed = sync_2 ^ ACTIVE_LOW;
    assign o_level = stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1        <= RELEASED_RAW;
            sync_2        <= RELEASED_RAW;
            cnt           <= '0;
            stable        <= 1'b0;
            o_press_pulse <= 1'b0;
        end else begin
            sync_1        <= i_raw;
            sync_2        <= sync_1;
            o_press_pulse <= 1'b0;
            if (pressed == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB - 1)) begin
                // DB consecutive differing samples: accept the new level.
                stable        <= pressed;
                cnt           <= '0;
                o_press_pulse <= pressed;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_cmd_conditioner.sv
// Debounced command pulses from raw push-buttons; cfg_1 wins a same-cycle tie with cfg_2.
// Pulse appears DB+3 edges after the raw press; level after DB+2. No backpressure.
module btn_cmd_conditioner
    import btn_cmd_conditioner_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 25_000_000,
    parameter int DEBOUNCE_US    = 10_000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_CNT-1:0] i_btn_raw,
    output logic               o_cmd_toggle_pause,
    output logic               o_cmd_load_cfg_1,
    output logic               o_cmd_load_cfg_2,
    output logic [BTN_CNT-1:0] o_btn_level
);

    localparam int DB = db_cycles(CLK_FREQ_HZ, DEBOUNCE_US);

    logic [BTN_CNT-1:0] level;
    logic [BTN_CNT-1:0] press;

    for (genvar g = 0; g < BTN_CNT; g++) begin : g_chan
        btn_cmd_conditioner_debounce_channel #(
            .DB         (DB),
            .ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_raw         (i_btn_raw[g]),
            .o_level       (level[g]),
            .o_press_pulse (press[g])
        );
    end

    assign o_btn_level = level;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cmd_toggle_pause <= 1'b0;
            o_cmd_load_cfg_1   <= 1'b0;
            o_cmd_load_cfg_2   <= 1'b0;
        end else begin
            o_cmd_toggle_pause <= press[BTN_PAUSE];
            o_cmd_load_cfg_1   <= press[BTN_CFG_1];
            // A cfg_2 press colliding with cfg_1 is dropped, not deferred.
            o_cmd_load_cfg_2   <= press[BTN_CFG_2] & ~press[BTN_CFG_1];
        end
    end

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Bench for btn_cmd_conditioner: vector table, hand-written corner sequences and
// randomized raw-pin traffic checked against a sliding-window reference model.
module tb_btn_cmd_conditioner;
    import btn_cmd_conditioner_pkg::*;

    localparam int DB = db_cycles(1_000_000, 8);

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] i_btn_raw;
    logic       o_cmd_toggle_pause;
    logic       o_cmd_load_cfg_1;
    logic       o_cmd_load_cfg_2;
    logic [2:0] o_btn_level;

    btn_cmd_conditioner #(
        .CLK_FREQ_HZ    (1_000_000),
        .DEBOUNCE_US    (8),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_btn_raw          (i_btn_raw),
        .o_cmd_toggle_pause (o_cmd_toggle_pause),
        .o_cmd_load_cfg_1   (o_cmd_load_cfg_1),
        .o_cmd_load_cfg_2   (o_cmd_load_cfg_2),
        .o_btn_level        (o_btn_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int inv_bad = 0;
    bit chk_model = 1'b0;

    // Reference model: pressed samples seen behind a 2-stage delay; a level is
    // accepted when the last DB samples all disagree with the current one.
    logic [2:0]  m_s1, m_s2, m_stable, m_evt, m_cmd;
    logic [63:0] m_hist [3];
    logic [63:0] mask;
    logic [2:0]  dut_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_evt = '0; m_cmd = '0;
        for (int c = 0; c < 3; c++) m_hist[c] = '0;
    endtask

    task automatic step(input logic [2:0] raw, input logic r);
        logic [2:0] nevt;
        i_btn_raw = raw;
        rst       = r;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            m_cmd = {m_evt[2] & ~m_evt[1], m_evt[1], m_evt[0]};
            nevt  = '0;
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = {m_hist[c][62:0], m_s2[c]};
                if ((m_hist[c] & mask) == (m_stable[c] ? 64'd0 : mask)) begin
                    m_stable[c] = ~m_stable[c];
                    nevt[c]     = m_stable[c];
                end
            end
            m_evt = nevt;
            m_s2  = m_s1;
            m_s1  = ~raw;
        end
        dut_cmd = {o_cmd_load_cfg_2, o_cmd_load_cfg_1, o_cmd_toggle_pause};
        if (dut_cmd[1] && dut_cmd[2]) inv_bad++;
        if (chk_model)
            check($sformatf("model_cyc%0d", cyc), {26'd0, dut_cmd, o_btn_level},
                  {26'd0, m_cmd, m_stable});
        cyc++;
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        int         n;
        logic [2:0] cmd;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl[$];

    localparam logic [2:0] REL = 3'b111;

    initial begin
        int cnt, first, bad, seg_len;
        logic [2:0] rv;
        mask = (64'd1 << DB) - 64'd1;
        model_reset();
        rst = 1'b1;
        i_btn_raw = REL;

        // Reset, clean pause press (40 cycles), release.
        tbl.push_back('{1'b1, REL,    3,  3'b000, 3'b000});
        tbl.push_back('{1'b0, 3'b110, 9,  3'b000, 3'b000});
        tbl.push_back('{1'b0, 3'b110, 1,  3'b000, 3'b001});
        tbl.push_back('{1'b0, 3'b110, 1,  3'b001, 3'b001});
        tbl.push_back('{1'b0, 3'b110, 29, 3'b000, 3'b001});
        tbl.push_back('{1'b0, REL,    9,  3'b000, 3'b001});
        tbl.push_back('{1'b0, REL,    10, 3'b000, 3'b000});
        // Simultaneous cfg_1 + cfg_2, then cfg_2 release and re-press.
        tbl.push_back('{1'b0, 3'b001, 9,  3'b000, 3'b000});
        tbl.push_back('{1'b0, 3'b001, 1,  3'b000, 3'b110});
        tbl.push_back('{1'b0, 3'b001, 1,  3'b010, 3'b110});
        tbl.push_back('{1'b0, 3'b001, 9,  3'b000, 3'b110});
        tbl.push_back('{1'b0, 3'b101, 9,  3'b000, 3'b110});
        tbl.push_back('{1'b0, 3'b101, 11, 3'b000, 3'b010});
        tbl.push_back('{1'b0, 3'b001, 9,  3'b000, 3'b010});
        tbl.push_back('{1'b0, 3'b001, 1,  3'b000, 3'b110});
        tbl.push_back('{1'b0, 3'b001, 1,  3'b100, 3'b110});
        tbl.push_back('{1'b0, 3'b001, 4,  3'b000, 3'b110});
        tbl.push_back('{1'b0, REL,    9,  3'b000, 3'b110});
        tbl.push_back('{1'b0, REL,    3,  3'b000, 3'b000});

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(tbl[i].raw, tbl[i].rst);
                check($sformatf("vec%0d_%0d", i, j),
                      {26'd0, dut_cmd, o_btn_level}, {26'd0, tbl[i].cmd, tbl[i].lvl});
            end
        end

        chk_model = 1'b1;

        // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed.
        cnt = 0; first = -1;
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < 3; k++) begin
                step((s % 2 == 0) ? 3'b110 : REL, 1'b0);
                if (o_cmd_toggle_pause) cnt++;
            end
        for (int k = 1; k <= 40; k++) begin
            step(3'b110, 1'b0);
            if (o_cmd_toggle_pause) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("bounce_pulse_count", cnt, 1);
        check("bounce_pulse_cycle", first, 11);

        // Glitch: 5-cycle release while held.
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            step((k < 5) ? REL : 3'b110, 1'b0);
            if (o_cmd_toggle_pause || !o_btn_level[0]) bad++;
        end
        check("glitch_no_effect", bad, 0);
        for (int k = 0; k < 15; k++) step(REL, 1'b0);
        check("glitch_released_level", {29'd0, o_btn_level}, 0);

        // Reset mid-count on cfg_2 (count reaches 4 after the 6th edge).
        for (int k = 0; k < 6; k++) step(3'b011, 1'b0);
        step(3'b011, 1'b1);
        check("rst_outputs_zero", {26'd0, dut_cmd, o_btn_level}, 0);
        cnt = 0; first = -1;
        for (int k = 1; k <= 25; k++) begin
            step(3'b011, 1'b0);
            if (o_cmd_load_cfg_2) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("rst_cfg2_pulse_count", cnt, 1);
        check("rst_cfg2_pulse_cycle", first, 11);
        for (int k = 0; k < 15; k++) step(REL, 1'b0);

        // Long hold of pause.
        cnt = 0;
        for (int k = 0; k < 1020; k++) begin
            step((k < 1000) ? 3'b110 : REL, 1'b0);
            if (o_cmd_toggle_pause) cnt++;
        end
        check("long_hold_pulse_count", cnt, 1);
        check("long_hold_level_after", {29'd0, o_btn_level}, 0);

        // Random raw traffic with occasional reset.
        for (int s = 0; s < 200; s++) begin
            rv = 3'($urandom_range(0, 7));
            seg_len = $urandom_range(1, 20);
            for (int k = 0; k < seg_len; k++) step(rv, 1'b0);
            if ($urandom_range(0, 49) == 0) step(rv, 1'b1);
        end

        check("load_mutual_exclusion", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
